// File: rtl/multi_timer_core_if.sv
// Command, status and lap-FIFO signals of multi_timer_core.
interface multi_timer_core_if #(
  parameter int N_CH    = 4,
  parameter int MAX_SEC = 359999
);
  localparam int TW = $clog2(MAX_SEC + 1);
  localparam int CW = $clog2(N_CH);

  logic [CW-1:0]   ch_sel;
  logic            cmd_start;
  logic            cmd_pause;
  logic            cmd_clear;
  logic            cmd_load;
  logic            cmd_lap;
  logic            cmd_mode;
  logic [TW-1:0]   load_value;
  logic            mode_val;
  logic [TW-1:0]   cur_time;
  logic [1:0]      cur_state;
  logic [N_CH-1:0] run_mask;
  logic [N_CH-1:0] expired;
  logic            alarm;
  logic            lap_rd;
  logic            lap_valid;
  logic [CW-1:0]   lap_ch;
  logic [TW-1:0]   lap_time;
  logic            lap_full;
  logic            lap_ovf;
  logic            ovf_clr;
  logic            tick;

  modport master (
    output ch_sel, cmd_start, cmd_pause, cmd_clear, cmd_load, cmd_lap, cmd_mode,
           load_value, mode_val, lap_rd, ovf_clr,
    input  cur_time, cur_state, run_mask, expired, alarm,
           lap_valid, lap_ch, lap_time, lap_full, lap_ovf, tick
  );

  modport slave (
    input  ch_sel, cmd_start, cmd_pause, cmd_clear, cmd_load, cmd_lap, cmd_mode,
           load_value, mode_val, lap_rd, ovf_clr,
    output cur_time, cur_state, run_mask, expired, alarm,
           lap_valid, lap_ch, lap_time, lap_full, lap_ovf, tick
  );
endinterface

// File: rtl/multi_timer_core.sv
// Multi-channel stopwatch/countdown timer with a shared 1 Hz prescaler
// and a first-word-fall-through lap FIFO.
module multi_timer_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int N_CH      = 4,
  parameter int LAP_DEPTH = 8,
  parameter int MAX_SEC   = 359999
) (
  input  logic                clk,
  input  logic                reset,
  multi_timer_core_if.slave   bus
);
  localparam int TW = $clog2(MAX_SEC + 1);
  localparam int CW = $clog2(N_CH);
  localparam int PW = $clog2(CLK_FREQ);
  localparam int AW = $clog2(LAP_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUNNING = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  localparam logic [TW-1:0] MAX_V = TW'(MAX_SEC);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PW'(CLK_FREQ - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Free-running prescaler shared by every channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // Priority decode: exactly one command (or none) survives per cycle
  logic sel_ok;
  logic c_clear, c_load, c_mode, c_start, c_pause, c_lap;

  assign sel_ok  = 32'(bus.ch_sel) < 32'(N_CH);
  assign c_clear = sel_ok & bus.cmd_clear;
  assign c_load  = sel_ok & ~bus.cmd_clear & bus.cmd_load;
  assign c_mode  = sel_ok & ~bus.cmd_clear & ~bus.cmd_load & bus.cmd_mode;
  assign c_start = sel_ok & ~bus.cmd_clear & ~bus.cmd_load & ~bus.cmd_mode & bus.cmd_start;
  assign c_pause = sel_ok & ~bus.cmd_clear & ~bus.cmd_load & ~bus.cmd_mode & ~bus.cmd_start
                 & bus.cmd_pause;
  assign c_lap   = sel_ok & ~bus.cmd_clear & ~bus.cmd_load & ~bus.cmd_mode & ~bus.cmd_start
                 & ~bus.cmd_pause & bus.cmd_lap;

  logic [N_CH-1:0][TW-1:0] val_vec;
  logic [N_CH-1:0][1:0]    st_vec;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [TW-1:0] val_q, val_d;
    logic [1:0]    st_q, st_d;
    logic          mode_q, mode_d;
    logic          hit;

    assign hit = (bus.ch_sel == CW'(g));

    // Tick update first; an accepted command then overrides it from the
    // registered value, so a coincident tick is discarded for this channel
    always_comb begin
      val_d  = val_q;
      st_d   = st_q;
      mode_d = mode_q;
      if (tick && st_q == RUNNING) begin
        if (!mode_q) begin
          val_d = (val_q == MAX_V) ? '0 : val_q + 1'b1;
        end else if (val_q <= TW'(1)) begin
          val_d = '0;
          st_d  = EXPIRED;
        end else begin
          val_d = val_q - 1'b1;
        end
      end
      if (hit) begin
        if (c_clear) begin
          val_d = '0;
          st_d  = IDLE;
        end else if (c_load) begin
          val_d = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
          st_d  = IDLE;
        end else if (c_mode) begin
          if (st_q == IDLE) begin
            mode_d = bus.mode_val;
            val_d  = '0;
          end
        end else if (c_start) begin
          if (st_q == EXPIRED) begin
            st_d  = IDLE;
            val_d = val_q;
          end else if ((st_q == IDLE || st_q == PAUSED) && !(mode_q && val_q == '0)) begin
            st_d  = RUNNING;
            val_d = val_q;
          end
        end else if (c_pause) begin
          if (st_q == RUNNING) begin
            st_d  = PAUSED;
            val_d = val_q;
          end
        end
      end
    end

    // Per-channel state registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        val_q  <= '0;
        st_q   <= IDLE;
        mode_q <= 1'b0;
      end else begin
        val_q  <= val_d;
        st_q   <= st_d;
        mode_q <= mode_d;
      end
    end

    assign val_vec[g]      = val_q;
    assign st_vec[g]       = st_q;
    assign bus.run_mask[g] = (st_q == RUNNING);
    assign bus.expired[g]  = (st_q == EXPIRED);
  end

  logic [TW-1:0] sel_time;

  assign sel_time      = sel_ok ? val_vec[bus.ch_sel] : '0;
  assign bus.cur_time  = sel_time;
  assign bus.cur_state = sel_ok ? st_vec[bus.ch_sel] : IDLE;
  assign bus.alarm     = |bus.expired;
  assign bus.tick      = tick;

  // Lap FIFO: extra pointer bit distinguishes full from empty
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] mem_ch_q   [LAP_DEPTH];
  logic [TW-1:0] mem_time_q [LAP_DEPTH];
  logic          empty, full, pop, push, ovf_q, ovf_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = bus.lap_rd & ~empty;
  assign push  = c_lap & (~full | pop);
  assign wr_d  = wr_q + (AW+1)'(push);
  assign rd_d  = rd_q + (AW+1)'(pop);
  assign ovf_d = (c_lap & full & ~pop) ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // FIFO storage captures the pre-tick value of the selected channel
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ch_q[wr_q[AW-1:0]]   <= bus.ch_sel;
      mem_time_q[wr_q[AW-1:0]] <= sel_time;
    end
  end

  assign bus.lap_valid = ~empty;
  assign bus.lap_full  = full;
  assign bus.lap_ovf   = ovf_q;
  assign bus.lap_ch    = mem_ch_q[rd_q[AW-1:0]];
  assign bus.lap_time  = mem_time_q[rd_q[AW-1:0]];
endmodule

// File: tb/tb_multi_timer_core.sv
// Scoreboard bench for multi_timer_core with a 10-cycle second.
module tb_multi_timer_core;
  localparam int CLK_FREQ  = 10;
  localparam int N_CH      = 4;
  localparam int LAP_DEPTH = 8;
  localparam int MAX_SEC   = 359999;
  localparam int TW        = 19;
  localparam int CW        = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_timer_core_if #(.N_CH(N_CH), .MAX_SEC(MAX_SEC)) bus ();

  multi_timer_core #(
    .CLK_FREQ(CLK_FREQ), .N_CH(N_CH), .LAP_DEPTH(LAP_DEPTH), .MAX_SEC(MAX_SEC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef enum int {F_TIME, F_STATE, F_RUN, F_EXP, F_ALARM, F_LVALID, F_LFULL, F_LOVF, F_TICK} field_e;
  typedef enum int {K_START, K_PAUSE, K_CLEAR, K_LOAD, K_LAP, K_MODE} cmd_e;
  typedef struct { string name; field_e f; int unsigned exp; } chk_t;
  typedef struct { int unsigned ch; int unsigned t; } lap_t;

  chk_t sb[$];
  lap_t lapq[$];
  int total = 0;
  int bad   = 0;

  function automatic int unsigned actual(input field_e f);
    case (f)
      F_TIME:   return 32'(bus.cur_time);
      F_STATE:  return 32'(bus.cur_state);
      F_RUN:    return 32'(bus.run_mask);
      F_EXP:    return 32'(bus.expired);
      F_ALARM:  return 32'(bus.alarm);
      F_LVALID: return 32'(bus.lap_valid);
      F_LFULL:  return 32'(bus.lap_full);
      F_LOVF:   return 32'(bus.lap_ovf);
      default:  return 32'(bus.tick);
    endcase
  endfunction

  // Monitor: pops expectations and checks popped lap entries on the falling edge
  always @(negedge clk) begin
    chk_t c;
    lap_t e;
    int unsigned a;
    if (bus.lap_rd && bus.lap_valid) begin
      total++;
      if (lapq.size() == 0) begin
        bad++;
        $display("FAIL lap_extra: got ch=%0d time=%0d, required no entry", bus.lap_ch, bus.lap_time);
      end else begin
        e = lapq.pop_front();
        if (32'(bus.lap_ch) != e.ch || 32'(bus.lap_time) != e.t) begin
          bad++;
          $display("FAIL lap_entry: got ch=%0d time=%0d, required ch=%0d time=%0d",
                   bus.lap_ch, bus.lap_time, e.ch, e.t);
        end
      end
    end
    while (sb.size() > 0) begin
      c = sb.pop_front();
      a = actual(c.f);
      total++;
      if (a != c.exp) begin
        bad++;
        $display("FAIL %s: got %0d, required %0d", c.name, a, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_v(input string n, input field_e f, input int unsigned e);
    chk_t c;
    c.name = n;
    c.f    = f;
    c.exp  = e;
    sb.push_back(c);
  endtask

  task automatic push_lap(input int unsigned ch, input int unsigned t);
    lap_t e;
    e.ch = ch;
    e.t  = t;
    lapq.push_back(e);
  endtask

  task automatic clr_cmds();
    bus.cmd_start = 1'b0;
    bus.cmd_pause = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_lap   = 1'b0;
    bus.cmd_mode  = 1'b0;
  endtask

  task automatic cmd(input cmd_e k, input int unsigned ch, input int unsigned v);
    bus.ch_sel     = CW'(ch);
    bus.load_value = TW'(v);
    bus.mode_val   = (v != 0);
    case (k)
      K_START: bus.cmd_start = 1'b1;
      K_PAUSE: bus.cmd_pause = 1'b1;
      K_CLEAR: bus.cmd_clear = 1'b1;
      K_LOAD:  bus.cmd_load  = 1'b1;
      K_LAP:   bus.cmd_lap   = 1'b1;
      default: bus.cmd_mode  = 1'b1;
    endcase
    step();
    clr_cmds();
  endtask

  task automatic wait_tick_pending();
    int n = 0;
    while (!bus.tick && n < 25) begin
      step();
      n++;
    end
    if (!bus.tick) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, required one within %0d", n, CLK_FREQ);
    end
  endtask

  task automatic wait_tick_edge();
    wait_tick_pending();
    step();
  endtask

  task automatic lap_read();
    step();
    bus.lap_rd = 1'b1;
    step();
    bus.lap_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.ch_sel     = '0;
    bus.load_value = '0;
    bus.mode_val   = 1'b0;
    bus.lap_rd     = 1'b0;
    bus.ovf_clr    = 1'b0;
    clr_cmds();
    repeat (3) step();
    reset = 1'b0;

    expect_v("rst_time", F_TIME, 0);
    expect_v("rst_state", F_STATE, 0);
    expect_v("rst_run", F_RUN, 0);
    expect_v("rst_exp", F_EXP, 0);
    expect_v("rst_alarm", F_ALARM, 0);
    expect_v("rst_lvalid", F_LVALID, 0);
    expect_v("rst_lfull", F_LFULL, 0);
    expect_v("rst_lovf", F_LOVF, 0);
    expect_v("rst_tick", F_TICK, 0);
    settle();

    // Stopwatch: 35 cycles after start cover exactly 3 ticks
    wait_tick_edge();
    cmd(K_START, 0, 0);
    repeat (35) step();
    expect_v("sw_time", F_TIME, 3);
    expect_v("sw_state", F_STATE, 1);
    expect_v("sw_run", F_RUN, 4'b0001);
    settle();
    cmd(K_PAUSE, 0, 0);
    expect_v("pause_time", F_TIME, 3);
    expect_v("pause_state", F_STATE, 2);
    expect_v("pause_run", F_RUN, 0);
    settle();
    repeat (15) step();
    expect_v("pause_frozen", F_TIME, 3);
    settle();

    // Countdown from 2 to expiry
    cmd(K_MODE, 1, 1);
    cmd(K_LOAD, 1, 2);
    expect_v("tmr_load", F_TIME, 2);
    expect_v("tmr_idle", F_STATE, 0);
    settle();
    cmd(K_START, 1, 0);
    expect_v("tmr_run", F_STATE, 1);
    settle();
    wait_tick_edge();
    expect_v("tmr_t1", F_TIME, 1);
    expect_v("tmr_t1_state", F_STATE, 1);
    settle();
    wait_tick_edge();
    expect_v("tmr_t0", F_TIME, 0);
    expect_v("tmr_expstate", F_STATE, 3);
    expect_v("tmr_expired", F_EXP, 4'b0010);
    expect_v("tmr_alarm", F_ALARM, 1);
    expect_v("tmr_run_mask", F_RUN, 0);
    settle();
    cmd(K_START, 1, 0);
    expect_v("ack_state", F_STATE, 0);
    expect_v("ack_time", F_TIME, 0);
    expect_v("ack_alarm", F_ALARM, 0);
    expect_v("ack_exp", F_EXP, 0);
    settle();
    cmd(K_START, 1, 0);
    expect_v("tmr_zero_start", F_STATE, 0);
    settle();

    // Load clamp and stopwatch wrap
    cmd(K_LOAD, 2, 524287);
    expect_v("load_clamp", F_TIME, 359999);
    expect_v("load_idle", F_STATE, 0);
    settle();
    cmd(K_START, 2, 0);
    wait_tick_edge();
    expect_v("wrap_time", F_TIME, 0);
    expect_v("wrap_state", F_STATE, 1);
    expect_v("wrap_run", F_RUN, 4'b0100);
    settle();

    // Clear on ch0 lands on a tick edge while ch3 counts
    wait_tick_edge();
    cmd(K_START, 0, 0);
    cmd(K_START, 3, 0);
    wait_tick_pending();
    cmd(K_CLEAR, 0, 0);
    expect_v("clr_tick_time", F_TIME, 0);
    expect_v("clr_tick_state", F_STATE, 0);
    expect_v("clr_tick_run", F_RUN, 4'b1100);
    settle();
    bus.ch_sel = 2'd3;
    expect_v("ch3_inc", F_TIME, 1);
    expect_v("ch3_state", F_STATE, 1);
    settle();

    // Lap FIFO fill, overflow, simultaneous push/pop, drain
    cmd(K_CLEAR, 2, 0);
    cmd(K_CLEAR, 3, 0);
    cmd(K_LOAD, 0, 100);
    cmd(K_LOAD, 1, 200);
    cmd(K_LOAD, 2, 300);
    cmd(K_LOAD, 3, 400);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push_lap(i % 4, 100 * (i % 4 + 1));
      cmd(K_LAP, i % 4, 0);
    end
    expect_v("fifo_valid", F_LVALID, 1);
    expect_v("fifo_full", F_LFULL, 1);
    expect_v("fifo_ovf", F_LOVF, 1);
    settle();
    bus.ovf_clr = 1'b1;
    cmd(K_LAP, 2, 0);
    bus.ovf_clr = 1'b0;
    expect_v("ovf_set_wins", F_LOVF, 1);
    expect_v("ovf_still_full", F_LFULL, 1);
    settle();
    step();
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    expect_v("ovf_cleared", F_LOVF, 0);
    settle();
    step();
    bus.lap_rd = 1'b1;
    push_lap(1, 200);
    cmd(K_LAP, 1, 0);
    bus.lap_rd = 1'b0;
    expect_v("pushpop_full", F_LFULL, 1);
    expect_v("pushpop_noovf", F_LOVF, 0);
    settle();
    repeat (8) lap_read();
    expect_v("drain_valid", F_LVALID, 0);
    expect_v("drain_full", F_LFULL, 0);
    settle();
    lap_read();
    expect_v("empty_rd", F_LVALID, 0);
    settle();

    // Reset mid-count with laps queued
    cmd(K_CLEAR, 0, 0);
    wait_tick_edge();
    cmd(K_START, 0, 0);
    repeat (5) wait_tick_edge();
    bus.ch_sel = 2'd0;
    expect_v("pre_rst_time", F_TIME, 5);
    expect_v("pre_rst_state", F_STATE, 1);
    settle();
    cmd(K_LAP, 0, 0);
    cmd(K_LAP, 0, 0);
    cmd(K_LAP, 0, 0);
    expect_v("pre_rst_lvalid", F_LVALID, 1);
    settle();
    reset = 1'b1;
    expect_v("mid_rst_time", F_TIME, 0);
    expect_v("mid_rst_state", F_STATE, 0);
    expect_v("mid_rst_run", F_RUN, 0);
    expect_v("mid_rst_exp", F_EXP, 0);
    expect_v("mid_rst_alarm", F_ALARM, 0);
    expect_v("mid_rst_lvalid", F_LVALID, 0);
    expect_v("mid_rst_lfull", F_LFULL, 0);
    expect_v("mid_rst_lovf", F_LOVF, 0);
    expect_v("mid_rst_tick", F_TICK, 0);
    settle();
    repeat (12) step();
    reset = 1'b0;
    expect_v("post_rst_time", F_TIME, 0);
    expect_v("post_rst_lvalid", F_LVALID, 0);
    settle();
    cmd(K_START, 1, 0);
    expect_v("rst_mode_sw", F_STATE, 1);
    settle();

    settle();
    total++;
    if (lapq.size() != 0) begin
      bad++;
      $display("FAIL lap_missing: got %0d entries unread, required 0", lapq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
